// File: rtl/link_pkg.sv
// -----------------------------------------------------------------------------
// link_pkg
// Shared definitions for the serial link receive path.
//   PAYLOAD_W    : width of one link payload word
//   HEADER_IDLE  : link header code for an idle frame
//   HEADER_DATA  : link header code for a data frame
//   rxb_state_e  : output-stage state of link_rx_buffer
//   payload_t    : one payload word
// No ports; imported by the link_rx_buffer files.
// -----------------------------------------------------------------------------
package link_pkg;

  localparam int PAYLOAD_W = 24;

  localparam logic [7:0] HEADER_IDLE = 8'h00;
  localparam logic [7:0] HEADER_DATA = 8'h01;

  typedef enum logic [0:0] {
    RXB_EMPTY = 1'b0,
    RXB_SHOW  = 1'b1
  } rxb_state_e;

  typedef logic [PAYLOAD_W-1:0] payload_t;

endpackage

// File: rtl/link_rx_buffer_if.sv
// -----------------------------------------------------------------------------
// link_rx_buffer_if
// Groups the link-side receive strobe/credit signals and the consumer-side
// valid/ready read port of the receive buffer.
//   receive_data          : payload word from the link
//   receive_data_valid    : one-cycle strobe qualifying receive_data
//   receive_data_consumed : one-cycle credit-return pulse per popped word
//   rd_data               : head-of-queue word (first-word-fall-through)
//   rd_valid              : rd_data valid
//   rd_ready              : consumer accepts rd_data
// Modports:
//   slave  : the buffer itself
//   master : the environment (link + consumer) around the buffer
// -----------------------------------------------------------------------------
interface link_rx_buffer_if;
  import link_pkg::*;

  payload_t receive_data;
  logic     receive_data_valid;
  logic     receive_data_consumed;
  payload_t rd_data;
  logic     rd_valid;
  logic     rd_ready;

  modport slave (
    input  receive_data,
    input  receive_data_valid,
    input  rd_ready,
    output receive_data_consumed,
    output rd_data,
    output rd_valid
  );

  modport master (
    output receive_data,
    output receive_data_valid,
    output rd_ready,
    input  receive_data_consumed,
    input  rd_data,
    input  rd_valid
  );

endinterface

// File: rtl/link_rx_buffer_mem.sv
// -----------------------------------------------------------------------------
// link_rx_buffer_mem
// DEPTH x PAYLOAD_W simple dual-port RAM: synchronous write, registered read.
// Contents are never reset.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address, sampled every cycle
//   o_rdata : registered read data (mem[i_raddr] of the previous edge)
// A read and write of the same address on one edge returns the old contents.
// -----------------------------------------------------------------------------
module link_rx_buffer_mem
  import link_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  payload_t      i_wdata,
  input  logic [AW-1:0] i_raddr,
  output payload_t      o_rdata
);

  payload_t r_mem [DEPTH];
  payload_t r_rdata;

  // Write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/link_rx_buffer.sv
// -----------------------------------------------------------------------------
// link_rx_buffer
// Receive-side elastic buffer behind the serial link. Every receive strobe is
// stored in a FIFO (no backpressure to the link); words leave through a
// first-word-fall-through valid/ready port, and each popped word returns one
// credit pulse to the link. Dropping the cable flushes the buffer.
//
// Ports:
//   clk             : clock, all logic on posedge
//   res_n           : synchronous active-low reset
//   cable_connected : low flushes pointers/level, ignores pushes
//   rx_if           : link_rx_buffer_if.slave (receive strobe, credit return,
//                     rd_data/rd_valid/rd_ready)
//   level           : stored word count, 0..DEPTH
//   full / empty    : level == DEPTH / level == 0
//   overflow        : sticky, a word was dropped because the buffer was full
//   stat_words      : (LINK_RX_BUFFER_STATS_EN) accepted pushes, saturating
//   stat_drops      : (LINK_RX_BUFFER_STATS_EN) dropped pushes, saturating
//
// Optional feature macro: LINK_RX_BUFFER_STATS_EN adds the two counters.
// -----------------------------------------------------------------------------
module link_rx_buffer
  import link_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic                cable_connected,
  link_rx_buffer_if.slave     rx_if,
  output logic [AW:0]         level,
  output logic                full,
  output logic                empty,
  output logic                overflow
`ifdef LINK_RX_BUFFER_STATS_EN
  ,
  output logic [31:0]         stat_words,
  output logic [15:0]         stat_drops
`endif
);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
  localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   LVL_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]   LVL_DEPTH = (AW+1)'(DEPTH);

  rxb_state_e    r_state;
  logic          r_rd_valid;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;
  logic          r_consumed;
  logic          r_byp;
  payload_t      r_byp_data;

  logic          w_flush;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic          w_drop;
  logic          w_collide;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [AW:0]   w_level_nxt;
  payload_t      w_ram_q;

  // Handshake decode. A full buffer still accepts a push when a pop frees
  // the head slot on the same edge.
  always_comb begin
    w_flush    = !cable_connected;
    w_pop      = r_rd_valid && rx_if.rd_ready;
    w_push_req = rx_if.receive_data_valid && cable_connected;
    w_push     = w_push_req && (!r_full || w_pop);
    w_drop     = w_push_req && r_full && !w_pop;
  end

  // Next pointer / level values, flush forces everything back to zero.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_level_nxt  = r_level;
    if (w_flush) begin
      w_wr_ptr_nxt = PTR_ZERO;
      w_rd_ptr_nxt = PTR_ZERO;
      w_level_nxt  = LVL_ZERO;
    end else begin
      w_wr_ptr_nxt = w_push ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
      w_rd_ptr_nxt = w_pop  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   w_level_nxt = r_level + LVL_ONE;
        2'b01:   w_level_nxt = r_level - LVL_ONE;
        default: w_level_nxt = r_level;
      endcase
    end
  end

  // The RAM is addressed with the next read pointer so a pop shows the
  // following word without a bubble. When that word is being written on the
  // same edge the RAM returns stale data, so the write data is bypassed.
  always_comb begin
    w_collide = w_push && (r_wr_ptr == w_rd_ptr_nxt);
  end

  link_rx_buffer_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (rx_if.receive_data),
    .i_raddr (w_rd_ptr_nxt),
    .o_rdata (w_ram_q)
  );

  // Pointers, level, decoded flags, credit return and read bypass.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_wr_ptr   <= PTR_ZERO;
      r_rd_ptr   <= PTR_ZERO;
      r_level    <= LVL_ZERO;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_consumed <= 1'b0;
      r_byp      <= 1'b1;
      r_byp_data <= {PAYLOAD_W{1'b0}};
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_level    <= w_level_nxt;
      r_full     <= (w_level_nxt == LVL_DEPTH);
      r_empty    <= (w_level_nxt == LVL_ZERO);
      r_overflow <= r_overflow || w_drop;
      // A pop on the flush-entry edge still returns its credit.
      r_consumed <= w_pop;
      r_byp      <= w_collide;
      r_byp_data <= w_collide ? rx_if.receive_data : r_byp_data;
    end
  end

  // Output FSM: EMPTY shows nothing, SHOW presents the head word.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_state    <= RXB_EMPTY;
      r_rd_valid <= 1'b0;
    end else if (w_flush) begin
      r_state    <= RXB_EMPTY;
      r_rd_valid <= 1'b0;
    end else begin
      case (r_state)
        RXB_EMPTY: begin
          if (r_level != LVL_ZERO) begin
            r_state    <= RXB_SHOW;
            r_rd_valid <= 1'b1;
          end else begin
            r_state    <= RXB_EMPTY;
            r_rd_valid <= 1'b0;
          end
        end
        RXB_SHOW: begin
          if (w_pop && (w_level_nxt == LVL_ZERO)) begin
            r_state    <= RXB_EMPTY;
            r_rd_valid <= 1'b0;
          end else begin
            r_state    <= RXB_SHOW;
            r_rd_valid <= 1'b1;
          end
        end
        default: begin
          r_state    <= RXB_EMPTY;
          r_rd_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.rd_valid              = r_rd_valid;
  assign rx_if.rd_data               = r_byp ? r_byp_data : w_ram_q;
  assign rx_if.receive_data_consumed = r_consumed;
  assign level                       = r_level;
  assign full                        = r_full;
  assign empty                       = r_empty;
  assign overflow                    = r_overflow;

`ifdef LINK_RX_BUFFER_STATS_EN
  logic [31:0] r_stat_words;
  logic [15:0] r_stat_drops;

  // Saturating traffic counters; a flush does not clear them.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_stat_words <= 32'd0;
      r_stat_drops <= 16'd0;
    end else begin
      if (w_push && (r_stat_words != {32{1'b1}})) begin
        r_stat_words <= r_stat_words + 32'd1;
      end
      if (w_drop && (r_stat_drops != {16{1'b1}})) begin
        r_stat_drops <= r_stat_drops + 16'd1;
      end
    end
  end

  assign stat_words = r_stat_words;
  assign stat_drops = r_stat_drops;
`endif

endmodule

// File: doc/link_rx_buffer.md
Name: link_rx_buffer

Overview:
- Receive-side elastic buffer directly downstream of the serial link block's receive interface.
- Captures each single-cycle receive_data_valid pulse into a FIFO and presents words to the local consumer with a valid/ready handshake.
- Returns one receive_data_consumed pulse per word popped, so the link's advertised buffer space tracks real occupancy.
- Flushes on cable disconnect.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridable.

Ports:
- clk  in  1  system clock, all logic on posedge.
- res_n  in  1  reset, synchronous, active-low.
- cable_connected  in  1  link cable present; low flushes the buffer.
- receive_data  in  24  payload word from the link.
- receive_data_valid  in  1  one-cycle strobe; receive_data is valid this cycle.
- receive_data_consumed  out  1  one-cycle credit-return pulse per popped word.
- rd_data  out  24  head-of-queue word, first-word-fall-through.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts rd_data when rd_valid && rd_ready.
- level  out  AW+1  number of stored words, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- overflow  out  1  sticky: a word was dropped because the buffer was full.

Behaviour:
- Reset (res_n low at posedge): pointers 0, level 0, rd_valid 0, rd_data 0, receive_data_consumed 0, full 0, empty 1, overflow 0. Memory contents are not reset.
- Push: on a cycle with receive_data_valid && !full, write receive_data at wr_ptr and increment wr_ptr (wraps modulo DEPTH).
  - If full, drop the word, set overflow, and leave level unchanged.
  - No backpressure exists toward the link; the peer's credit counter normally prevents overflow.
- Pop: rd_valid && rd_ready increments rd_ptr (wraps). receive_data_consumed is high exactly one cycle later, exactly once per pop.
- Output uses a two-state FSM:
  - EMPTY: rd_valid=0.
  - SHOW: rd_valid=1, rd_data=mem[rd_ptr] registered.
  - EMPTY->SHOW the cycle after level becomes nonzero; write-to-rd_valid latency is 1 cycle.
  - SHOW->EMPTY after a pop that leaves level 0.
  - SHOW->SHOW on a pop with level>1; the next word appears the following cycle with no bubble.
- Simultaneous push and pop:
  - Non-empty: level unchanged, both pointers advance.
  - Full: the pop frees the slot first, so the push is accepted; no overflow.
  - Empty: the push is stored and the pop is impossible (rd_valid=0).
- level is an AW+1-bit counter: +1 on push only, -1 on pop only, held otherwise. full and empty are decoded from the registered level.
- Flush: while cable_connected=0, pointers and level go to 0, the FSM goes to EMPTY, pushes are ignored, and no consumed pulses are issued, since the remote credit state is reset by the link. overflow is kept. A pop accepted in the same cycle as a flush entry still produces its consumed pulse.
- rd_data is held stable while rd_valid && !rd_ready.

Optional Feature:
- Macro LINK_RX_BUFFER_STATS_EN.
- Defined: adds outputs stat_words (32-bit, +1 per accepted push, saturating at all ones) and stat_drops (16-bit, +1 per dropped push, saturating). Both reset to 0 and are not cleared by flush.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package link_pkg:
  - PAYLOAD_W=24.
  - HEADER_IDLE=8'h00, HEADER_DATA=8'h01.
  - Output FSM state enum {RXB_EMPTY, RXB_SHOW}.
- Sub-module link_rx_buffer_mem: DEPTH x 24 simple dual-port RAM, synchronous write, registered read. The top holds pointers, level, FSM, credit return and flags.

Test Plan:
- Reset, then 3 pushes 0x000001/0x000002/0x000003 with rd_ready=0 -> level=3; rd_valid rises 1 cycle after the first push with rd_data=0x000001; no consumed pulses.
- rd_ready=1 held -> words popped in order 1,2,3 on consecutive cycles; 3 consumed pulses, each 1 cycle after its pop; empty=1 at the end.
- DEPTH=16: 17 pushes with rd_ready=0 -> full=1, overflow=1, level=16; word 17 absent on readout.
- Full buffer, push 0xABCDEF and pop on the same cycle -> level stays 16, overflow stays 0, 0xABCDEF is last out.
- 5 words stored, cable_connected=0 for 1 cycle -> level=0, rd_valid=0 next cycle, no consumed pulses; subsequent push 0x000055 is read out first.
- 40 push/pop pairs across pointer wrap -> data order preserved, exactly 40 consumed pulses, level never exceeds 1.
